// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and init-sequencer state type.
// Reused by the init, refresh and read/write controllers.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NOP  = 4'b0111;
  localparam cmd_t CMD_PRE  = 4'b0010;
  localparam cmd_t CMD_AREF = 4'b0001;
  localparam cmd_t CMD_LMR  = 4'b0000;

  typedef enum logic [2:0] {
    StWaitPwr,
    StPre,
    StWaitTrp,
    StAref,
    StWaitTrfc,
    StMrs,
    StWaitTmrd,
    StDone
  } init_state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialisation sequencer: power wait, precharge-all, auto-refreshes,
// load-mode-register, with run-time re-initialisation from DONE.
module sdram_init_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned         ADDR_W      = 12,
  parameter int unsigned         BA_W        = 2,
  parameter int unsigned         T_POWER_CYC = 10000,
  parameter int unsigned         T_RP        = 2,
  parameter int unsigned         T_RFC       = 7,
  parameter int unsigned         T_MRD       = 3,
  parameter int unsigned         AREF_NUM    = 8,
  parameter logic [ADDR_W-1:0]   MODE_REG    = 'h037
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              reinit_req,
  output logic [3:0]        init_cmd,
  output logic [BA_W-1:0]   init_ba,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_done,
  output logic              init_busy
);

  localparam int unsigned TMax = max4(T_POWER_CYC, T_RP, T_RFC, T_MRD);
  localparam int unsigned CntW = $clog2(TMax) + 1;
  localparam int unsigned RefW = $clog2(AREF_NUM + 1);

  localparam logic [CntW-1:0] LdPwr = CntW'(T_POWER_CYC - 1);
  localparam logic [CntW-1:0] LdRp  = CntW'(T_RP - 1);
  localparam logic [CntW-1:0] LdRfc = CntW'(T_RFC - 1);
  localparam logic [CntW-1:0] LdMrd = CntW'(T_MRD - 1);

  // A10 high selects all banks for PRECHARGE.
  localparam logic [ADDR_W-1:0] AddrPre = ADDR_W'(1) << 10;

  init_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RefW-1:0]   ref_q, ref_d;
  cmd_t              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;

    unique case (state_q)
      StWaitPwr: begin
        if (cnt_q == '0) state_d = StPre;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StPre: state_d = StWaitTrp;
      StWaitTrp: begin
        if (cnt_q == '0) state_d = StAref;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StAref: begin
        state_d = StWaitTrfc;
        ref_d   = ref_q + 1'b1;
      end
      StWaitTrfc: begin
        if (cnt_q == '0) state_d = (ref_q == RefW'(AREF_NUM)) ? StMrs : StAref;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StMrs: state_d = StWaitTmrd;
      StWaitTmrd: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StDone: begin
        if (reinit_req) state_d = StPre;
      end
      default: state_d = StWaitPwr;
    endcase

    // Reload the shared timer on every state entry; the value is only used by wait states.
    if (state_d != state_q) begin
      unique case (state_d)
        StWaitPwr:  cnt_d = LdPwr;
        StWaitTrp:  cnt_d = LdRp;
        StWaitTrfc: cnt_d = LdRfc;
        StWaitTmrd: cnt_d = LdMrd;
        default:    cnt_d = '0;
      endcase
      if (state_d == StPre) ref_d = '0;
    end
  end

  // Outputs are decoded from the next state so they appear on the entering edge.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    unique case (state_d)
      StPre: begin
        cmd_d  = CMD_PRE;
        addr_d = AddrPre;
      end
      StAref: cmd_d = CMD_AREF;
      StMrs: begin
        cmd_d  = CMD_LMR;
        addr_d = MODE_REG;
      end
      default: ;
    endcase
    done_d = (state_d == StDone);
    busy_d = (state_d != StDone);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StWaitPwr;
      cnt_q   <= LdPwr;
      ref_q   <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign init_cmd  = cmd_q;
  assign init_ba   = '0;
  assign init_addr = addr_q;
  assign init_done = done_q;
  assign init_busy = busy_q;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Bench for sdram_init_ctrl: queue-based sequence model checked every cycle, plus
// directed literal checks for cold start, re-init, ignored requests and mid-sequence reset.
module tb_sdram_init_ctrl;
  import sdram_pkg::*;

  localparam int unsigned TPWR  = 10000;
  localparam int unsigned TRP   = 2;
  localparam int unsigned TRFC  = 7;
  localparam int unsigned TMRD  = 3;
  localparam int unsigned NAREF = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        reinit_req = 1'b0;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [11:0] init_addr;
  logic        init_done, init_busy;

  logic [3:0]  cmd2;
  logic [1:0]  ba2;
  logic [12:0] addr2;
  logic        done2, busy2;

  always #5 sys_clk = ~sys_clk;

  sdram_init_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .reinit_req (reinit_req),
    .init_cmd   (init_cmd),
    .init_ba    (init_ba),
    .init_addr  (init_addr),
    .init_done  (init_done),
    .init_busy  (init_busy)
  );

  sdram_init_ctrl #(
    .ADDR_W      (13),
    .BA_W        (2),
    .T_POWER_CYC (20),
    .T_RP        (3),
    .T_RFC       (9),
    .T_MRD       (3),
    .AREF_NUM    (2)
  ) dut2 (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .reinit_req (1'b0),
    .init_cmd   (cmd2),
    .init_ba    (ba2),
    .init_addr  (addr2),
    .init_done  (done2),
    .init_busy  (busy2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 50)
        $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Expected outputs after each clock edge, derived from the command-sequence rules.
  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_cur = '{cmd: CMD_NOP, addr: 12'h000, done: 1'b0};

  function automatic exp_t mk(input logic [3:0] c, input logic [11:0] a, input logic d);
    exp_t e;
    e.cmd  = c;
    e.addr = a;
    e.done = d;
    return e;
  endfunction

  task automatic load_seq(input bit with_pwr);
    exp_q.delete();
    if (with_pwr) repeat (TPWR - 1) exp_q.push_back(mk(CMD_NOP, 12'h000, 1'b0));
    exp_q.push_back(mk(CMD_PRE, 12'h400, 1'b0));
    repeat (TRP) exp_q.push_back(mk(CMD_NOP, 12'h000, 1'b0));
    for (int i = 0; i < NAREF; i++) begin
      exp_q.push_back(mk(CMD_AREF, 12'h000, 1'b0));
      repeat (TRFC) exp_q.push_back(mk(CMD_NOP, 12'h000, 1'b0));
    end
    exp_q.push_back(mk(CMD_LMR, 12'h037, 1'b0));
    repeat (TMRD) exp_q.push_back(mk(CMD_NOP, 12'h000, 1'b0));
  endtask

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      load_seq(1'b1);
      m_cur = mk(CMD_NOP, 12'h000, 1'b0);
    end else if (exp_q.size() > 0) begin
      m_cur = exp_q.pop_front();
    end else if (m_cur.done && reinit_req) begin
      load_seq(1'b0);
      m_cur = exp_q.pop_front();
    end else begin
      m_cur = mk(CMD_NOP, 12'h000, 1'b1);
    end
  end

  always @(negedge sys_clk) begin
    check("model_cmd", 32'(init_cmd), 32'(m_cur.cmd));
    check("model_addr", 32'(init_addr), 32'(m_cur.addr));
    check("model_done", 32'(init_done), 32'(m_cur.done));
    check("ba_zero", 32'(init_ba), 32'd0);
    check("done_vs_busy", 32'(init_busy), 32'(!init_done));
    check("cmd_legal", 32'(init_cmd inside {CMD_NOP, CMD_PRE, CMD_AREF, CMD_LMR}), 32'd1);
    check("dut2_ba_zero", 32'(ba2), 32'd0);
    check("dut2_done_vs_busy", 32'(busy2), 32'(!done2));
    check("dut2_cmd_legal", 32'(cmd2 inside {CMD_NOP, CMD_PRE, CMD_AREF, CMD_LMR}), 32'd1);
  end

  int aref2_cnt = 0;
  int pre_cnt = 0;
  always @(negedge sys_clk) begin
    if (sys_rst) aref2_cnt = 0;
    else if (cmd2 == CMD_AREF) aref2_cnt++;
    if (!sys_rst && init_cmd == CMD_PRE) pre_cnt++;
  end

  int p0;

  initial begin
    #1 sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_cmd", 32'(init_cmd), 32'h7);
    check("rst_addr", 32'(init_addr), 32'h0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(init_busy), 32'd1);
    #1 sys_rst = 1'b0;

    // Cold start; the small instance finishes early in this window.
    repeat (20) @(posedge sys_clk);
    #1;
    check("sweep_pre_cmd", 32'(cmd2), 32'h2);
    check("sweep_pre_addr", 32'(addr2), 32'h0400);
    repeat (27) @(posedge sys_clk);
    #1 check("sweep_done_47", 32'(done2), 32'd0);
    @(posedge sys_clk);
    #1;
    check("sweep_done_48", 32'(done2), 32'd1);
    check("sweep_aref_count", 32'(aref2_cnt), 32'd2);
    repeat (10000 - 48) @(posedge sys_clk);
    #1;
    check("cold_pre_cmd", 32'(init_cmd), 32'h2);
    check("cold_pre_addr", 32'(init_addr), 32'h400);

    // Request during a refresh wait must be ignored.
    repeat (5) @(posedge sys_clk);
    #1 reinit_req = 1'b1;
    @(posedge sys_clk);
    #1 reinit_req = 1'b0;
    repeat (64) @(posedge sys_clk);
    #1 check("cold_done_10070", 32'(init_done), 32'd0);
    @(posedge sys_clk);
    #1;
    check("cold_done_10071", 32'(init_done), 32'd1);
    check("cold_done_nop", 32'(init_cmd), 32'h7);

    // Re-init from DONE.
    repeat (3) @(posedge sys_clk);
    #1 reinit_req = 1'b1;
    @(posedge sys_clk);
    #1;
    check("reinit_pre_cmd", 32'(init_cmd), 32'h2);
    check("reinit_done_low", 32'(init_done), 32'd0);
    check("reinit_busy_high", 32'(init_busy), 32'd1);
    reinit_req = 1'b0;
    repeat (67) @(posedge sys_clk);
    #1;
    check("reinit_lmr_cmd", 32'(init_cmd), 32'h0);
    check("reinit_lmr_addr", 32'(init_addr), 32'h037);
    repeat (3) @(posedge sys_clk);
    #1 check("reinit_done_70", 32'(init_done), 32'd0);
    @(posedge sys_clk);
    #1 check("reinit_done_71", 32'(init_done), 32'd1);

    // Held-high request: one PRE per 72-edge sequence.
    p0 = pre_cnt;
    reinit_req = 1'b1;
    repeat (200) @(posedge sys_clk);
    #1 reinit_req = 1'b0;
    check("held_pre_count", 32'(pre_cnt - p0), 32'd3);
    repeat (80) @(posedge sys_clk);
    #1 check("held_settles_done", 32'(init_done), 32'd1);

    // Reset mid-sequence during the 5th refresh wait.
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (10038) @(posedge sys_clk);
    #3 sys_rst = 1'b1;
    #1;
    check("midrst_cmd", 32'(init_cmd), 32'h7);
    check("midrst_addr", 32'(init_addr), 32'h0);
    check("midrst_done", 32'(init_done), 32'd0);
    check("midrst_busy", 32'(init_busy), 32'd1);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (10070) @(posedge sys_clk);
    #1 check("restart_done_10070", 32'(init_done), 32'd0);
    @(posedge sys_clk);
    #1 check("restart_done_10071", 32'(init_done), 32'd1);

    repeat (2) @(posedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_init_ctrl.md
# sdram_init_ctrl

Parametrised SDRAM power-up initialisation sequencer that supersedes the fixed-function init block. It sits between the system clock/reset and the SDRAM command mux. After reset it drives the JEDEC start-up sequence onto a command/bank/address bus: power-up wait, precharge-all, N auto-refreshes, then load-mode-register. Unlike its predecessor, it is generic in address and bank width, timing, refresh count and mode word, and it accepts a run-time re-initialisation request.

## Interface
- ADDR_W, 12, SDRAM address bus width; must be ≥ 11 because A10 is the precharge-all bit.
- BA_W, 2, bank address width.
- T_POWER_CYC, 10000, power-up NOP wait in clock cycles; must be ≥ 1.
- T_RP, 2, NOP cycles after PRECHARGE; must be ≥ 1.
- T_RFC, 7, NOP cycles after each AUTO_REFRESH; must be ≥ 1.
- T_MRD, 3, NOP cycles after LOAD_MODE; must be ≥ 1.
- AREF_NUM, 8, number of AUTO_REFRESH commands; must be ≥ 1.
- MODE_REG, 'b0_0_00_011_0_111 zero-extended to ADDR_W, mode word driven on the address bus during LOAD_MODE.
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- reinit_req  in  1  single-cycle re-initialisation request; honoured only in DONE.
- init_cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- init_ba  out  BA_W  bank address; always 0.
- init_addr  out  ADDR_W  address bus.
- init_done  out  1  high while in DONE.
- init_busy  out  1  high in every state except DONE.

## Operation
- Commands: NOP = 4'b0111, PRECHARGE = 4'b0010, AUTO_REFRESH = 4'b0001, LOAD_MODE = 4'b0000.
- FSM states: WAIT_PWR → PRE → WAIT_TRP → AREF → WAIT_TRFC → (AREF again if refreshes remain, else MRS) → WAIT_TMRD → DONE.
- WAIT_PWR, WAIT_TRP, WAIT_TRFC and WAIT_TMRD each last exactly T_POWER_CYC, T_RP, T_RFC and T_MRD cycles respectively, and drive NOP. PRE, AREF and MRS each last exactly one cycle.
- init_addr:
  - bit 10 = 1 and all other bits 0 during PRE;
  - MODE_REG during MRS;
  - all zeros otherwise.
- A single shared down-counter times every wait state. Its width is $clog2 of the largest timing parameter plus 1, and it is reloaded on each state entry.
- A refresh counter of width $clog2(AREF_NUM+1) counts issued AUTO_REFRESH commands. It is cleared on entry to PRE.
- In DONE, the block outputs NOP, and both counters hold.
- reinit_req:
  - In DONE, it moves the FSM to PRE on the next edge; the power-up wait is skipped.
  - In any other state it is ignored; requests are not queued.

## Timing
- Reset values (asynchronous): state WAIT_PWR; init_cmd NOP; init_ba 0; init_addr 0; init_done 0; init_busy 1; counters loaded for WAIT_PWR.
- All outputs are registered. They change only on sys_clk edges, or asynchronously at reset assertion.
- Cold-start latency: init_done rises N = T_POWER_CYC + 1 + T_RP + AREF_NUM·(1+T_RFC) + 1 + T_MRD edges after the first edge with sys_rst low. With defaults, N = 10071.
- Re-init latency:
  - PRECHARGE appears on the edge that samples reinit_req = 1 in DONE.
  - init_done and init_busy change on that same edge.
  - init_done returns after 1 + T_RP + AREF_NUM·(1+T_RFC) + 1 + T_MRD edges (71 with defaults).
- Reset mid-sequence, in any state: outputs go immediately to their reset values, and the full sequence, including the power wait, restarts.
- reinit_req held high continuously: the block re-enters PRE once per completed sequence, because each DONE visit lasts exactly one cycle.
- init_done and init_busy are always complementary.

## Structure
- Package sdram_pkg holds the cmd_t 4-bit typedef, the CMD_NOP, CMD_PRE, CMD_AREF and CMD_LMR constants, and the init state enum. The future refresh and read/write controllers reuse it.
- The block is a single module with no sub-modules. The wait counter is inline.

## Test plan
- Cold start with defaults: release sys_rst → NOP for 10000 cycles; PRECHARGE with addr 12'h400; 8 AUTO_REFRESH commands spaced 8 cycles apart; LOAD_MODE with addr 12'h037; init_done high at edge 10071 and held.
- Parameter sweep (ADDR_W=13, BA_W=2, T_RP=3, T_RFC=9, AREF_NUM=2, T_POWER_CYC=20): PRECHARGE addr 13'h0400; init_done at edge 20+1+3+20+1+3 = 48.
- reinit_req pulse in DONE → PRECHARGE on the sampling edge; init_done low, init_busy high, for 71 cycles; the full command sequence repeats with no power wait.
- reinit_req pulsed during WAIT_TRFC → no change to the command sequence or to the 10071-cycle timing.
- sys_rst asserted during the 5th AREF wait, between clock edges → outputs are NOP/0 immediately; after release, the sequence restarts with the full power wait and init_done at edge 10071.
- Throughout every test: a bench assertion checks that init_ba is always 0, init_done equals ~init_busy, and the only commands ever driven are NOP, PRECHARGE, AUTO_REFRESH and LOAD_MODE.
